// File: rtl/board_input_conditioner.sv
// Board input conditioner: per-input synchroniser and debounce FSM timed by a
// shared prescaler, producing clean levels, edge pulses and sticky pending bits.
module board_input_conditioner #(
  parameter int   NUM_IN       = 4,
  parameter int   SYNC_STAGES  = 2,
  parameter int   TICK_DIV     = 1000,
  parameter int   STABLE_TICKS = 10,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] pad_i,
  output logic [NUM_IN-1:0] level_o,
  output logic [NUM_IN-1:0] rise_o,
  output logic [NUM_IN-1:0] fall_o,
  output logic [NUM_IN-1:0] pend_o,
  input  logic [NUM_IN-1:0] clr_i
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } state_t;

  logic [NUM_IN-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0]     r_pre;
  state_t            r_state [NUM_IN];
  logic [CW-1:0]     r_cnt [NUM_IN];
  logic [NUM_IN-1:0] r_level;
  logic [NUM_IN-1:0] r_level_d;
  logic [NUM_IN-1:0] r_rise;
  logic [NUM_IN-1:0] r_fall;
  logic [NUM_IN-1:0] r_pend;

  logic [NUM_IN-1:0] w_sync;
  logic              w_tick;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= {NUM_IN{RESET_LEVEL}};
    end else begin
      r_sync[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else r_pre <= r_pre + PW'(1);
  end

  // A glitch back to the current level always wins over a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= {NUM_IN{RESET_LEVEL}};
      for (int k = 0; k < NUM_IN; k++) begin
        r_state[k] <= ST_STABLE;
        r_cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        unique case (r_state[k])
          ST_STABLE: begin
            if (w_sync[k] != r_level[k]) begin
              r_state[k] <= ST_CHANGING;
              r_cnt[k]   <= '0;
            end
          end
          ST_CHANGING: begin
            if (w_sync[k] == r_level[k]) begin
              r_state[k] <= ST_STABLE;
              r_cnt[k]   <= '0;
            end else if (w_tick) begin
              if (r_cnt[k] == CW'(STABLE_TICKS - 1)) begin
                r_level[k] <= w_sync[k];
                r_state[k] <= ST_STABLE;
                r_cnt[k]   <= '0;
              end else begin
                r_cnt[k] <= r_cnt[k] + CW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= {NUM_IN{RESET_LEVEL}};
      r_rise    <= '0;
      r_fall    <= '0;
      r_pend    <= '0;
    end else begin
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      r_fall    <= ~r_level & r_level_d;
      r_pend    <= (r_pend & ~clr_i) | r_rise | r_fall;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign pend_o  = r_pend;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner: directed scenarios plus random pad activity,
// checked against a run-length/tick-count reference model through a scoreboard.
module tb_board_input_conditioner;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pad_i = '0;
  logic [N-1:0] clr_i = '0;
  logic [N-1:0] level_o, rise_o, fall_o, pend_o;

  board_input_conditioner #(
    .NUM_IN(N), .SYNC_STAGES(SS), .TICK_DIV(TD),
    .STABLE_TICKS(ST), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pad_i(pad_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .pend_o(pend_o), .clr_i(clr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    int   b;
    logic dir;
    int   vis;
  } ev_t;

  ev_t          q[$];
  logic [N-1:0] m_lvl;
  logic [N-1:0] m_pend;
  int           m_n;
  logic [N-1:0] hist[$];
  logic [N-1:0] acc[$];
  int           mstart[N];

  // Ticks fall on edges n with (n+1) % TD == 0; count those in (a, b].
  function automatic int ticks_between(input int a, input int b);
    return (b + 1) / TD - (a + 1) / TD;
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] s;
    logic [N-1:0] a;
    ev_t          e;
    if (rst) begin
      m_lvl  = '0;
      m_pend = '0;
      m_n    = 0;
      hist.delete();
      acc.delete();
      q.delete();
      for (int k = 0; k < N; k++) mstart[k] = -1;
    end else begin
      hist.push_back(pad_i);
      s = (m_n >= SS) ? hist[m_n-SS] : '0;
      a = '0;
      for (int k = 0; k < N; k++) begin
        if (s[k] == m_lvl[k]) mstart[k] = -1;
        else if (mstart[k] < 0) mstart[k] = m_n;
        else if (ticks_between(mstart[k], m_n) == ST) begin
          a[k] = 1'b1;
          mstart[k] = -1;
        end
      end
      m_lvl = m_lvl ^ a;
      for (int k = 0; k < N; k++) begin
        if (a[k]) begin
          e.b = k; e.dir = m_lvl[k]; e.vis = m_n + 2;
          q.push_back(e);
        end
      end
      acc.push_back(a);
      m_pend = (m_pend & ~clr_i) | ((m_n >= 2) ? acc[m_n-2] : '0);
      m_n++;
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    if (!rst && m_n > 0) begin
      chk("level", level_o, m_lvl);
      chk("pend", pend_o, m_pend);
      chk("rise_fall_excl", rise_o & fall_o, '0);
      for (int k = 0; k < N; k++) begin
        if (rise_o[k] || fall_o[k]) begin
          if (q.size() == 0) begin
            chk("unexpected_edge", k, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("edge_bit", k, e.b);
            chk("edge_dir", rise_o[k], e.dir);
            chk("edge_time", m_n, e.vis);
          end
        end
      end
      while (q.size() > 0 && q[0].vis < m_n) begin
        e = q.pop_front();
        chk("missed_edge", e.b, 32'hFFFF_FFFF);
      end
    end
  end

  task automatic wait_level0(input logic v, input string name);
    int i;
    for (i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (level_o[0] == v) break;
    end
    chk(name, (i <= 15), 1);
  endtask

  initial begin
    int hold;
    int k;
    int i;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {level_o, rise_o, fall_o, pend_o}, '0);
    rst = 1'b0;

    repeat (50) @(negedge clk);
    chk("t1_idle", {level_o, pend_o}, '0);

    pad_i[0] = 1'b1;
    wait_level0(1'b1, "t2_latency");
    repeat (10) @(negedge clk);
    chk("t2_pend", pend_o, 4'b0001);

    pad_i[1] = 1'b1;
    repeat (5) @(negedge clk);
    pad_i[1] = 1'b0;
    repeat (40) @(negedge clk);
    chk("t3_glitch", {level_o[1], pend_o[1]}, 2'b00);

    pad_i[3:2] = 2'b11;
    repeat (40) @(negedge clk);
    chk("t4_pend", pend_o[3:2], 2'b11);

    pad_i[0] = 1'b0;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fall_o[0]) break;
    end
    chk("t5_fall_seen", (i < 40), 1);
    clr_i[0] = 1'b1;
    @(negedge clk);
    clr_i[0] = 1'b0;
    chk("t5_set_wins", pend_o[0], 1'b1);
    repeat (3) @(negedge clk);
    clr_i[0] = 1'b1;
    @(negedge clk);
    clr_i[0] = 1'b0;
    chk("t5_cleared", pend_o[0], 1'b0);

    pad_i[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_changing", level_o[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_async_reset", {level_o, rise_o, fall_o, pend_o}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_level0(1'b1, "t6_latency");
    repeat (10) @(negedge clk);
    chk("t6_pend", pend_o[0], 1'b1);

    for (int it = 0; it < 150; it++) begin
      k = $urandom_range(N-1, 0);
      pad_i[k] = ~pad_i[k];
      hold = $urandom_range(20, 1);
      for (int h = 0; h < hold; h++) begin
        clr_i = ($urandom_range(7, 0) == 0) ? N'($urandom) : '0;
        @(negedge clk);
      end
    end
    clr_i = '0;
    repeat (60) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
